// File: rtl/code_search_ctrl.sv
// Serial code-phase search controller for one tracking channel.
// Walks the upsampler through code-shift bins over the seek handshake,
// clears the accumulator, sums a programmable number of dumps per bin
// and reports the bin with the largest sum. All outputs are registered.
module code_search_ctrl #(
  parameter int CS_WIDTH       = 11,
  parameter int MAX_CODE_SHIFT = 2045,
  parameter int ACC_WIDTH      = 24,
  parameter int DWELL_WIDTH    = 8,
  parameter int SUM_WIDTH      = ACC_WIDTH + DWELL_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [CS_WIDTH-1:0]    step_i,
  input  logic [DWELL_WIDTH-1:0] dwell_count_i,
  input  logic [SUM_WIDTH-1:0]   threshold_i,
  output logic                   seek_en_o,
  output logic [CS_WIDTH-1:0]    seek_target_o,
  input  logic                   seeking_i,
  output logic                   acc_clear_o,
  input  logic                   acc_valid_i,
  input  logic [ACC_WIDTH-1:0]   acc_mag_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   found_o,
  output logic [CS_WIDTH-1:0]    best_shift_o,
  output logic [SUM_WIDTH-1:0]   best_mag_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEEK, S_SETTLE, S_CLEAR, S_DWELL, S_EVAL, S_DONE
  } state_e;

  // Sweep end is decided one bit wider than the shift so a large step cannot wrap.
  localparam logic [CS_WIDTH:0] MAX_SHIFT_EXT = (CS_WIDTH + 1)'(MAX_CODE_SHIFT);

  state_e                 state_q;
  logic                   seek_en_q;
  logic [CS_WIDTH-1:0]    seek_target_q;
  logic                   acc_clear_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   found_q;
  logic [CS_WIDTH-1:0]    best_shift_q;
  logic [SUM_WIDTH-1:0]   best_mag_q;
  logic [CS_WIDTH-1:0]    cur_shift_q;
  logic [CS_WIDTH-1:0]    step_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic [SUM_WIDTH-1:0]   thr_q;
  logic [DWELL_WIDTH-1:0] dump_cnt_q;
  logic [SUM_WIDTH-1:0]   bin_sum_q;

  logic                   bin_wins;
  logic [SUM_WIDTH-1:0]   best_mag_d;
  logic [CS_WIDTH:0]      next_shift;

  // Strict compare keeps the earliest shift on ties; found is judged on the updated best.
  assign bin_wins   = bin_sum_q > best_mag_q;
  assign best_mag_d = bin_wins ? bin_sum_q : best_mag_q;
  assign next_shift = {1'b0, cur_shift_q} + {1'b0, step_q};

  // Sweep sequencer with all outputs and datapath registers in one process.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      seek_en_q     <= 1'b0;
      seek_target_q <= '0;
      acc_clear_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      best_shift_q  <= '0;
      best_mag_q    <= '0;
      cur_shift_q   <= '0;
      step_q        <= CS_WIDTH'(1);
      dwell_q       <= DWELL_WIDTH'(1);
      thr_q         <= '0;
      dump_cnt_q    <= '0;
      bin_sum_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every branch reads
      // the pre-edge register values regardless of statement order; the two
      // pulse outputs default low and are raised only in the cycle they fire.
      acc_clear_q <= 1'b0;
      done_q      <= 1'b0;
      if (abort_i && state_q != S_IDLE) begin
        state_q   <= S_IDLE;
        seek_en_q <= 1'b0;
        busy_q    <= 1'b0;
        found_q   <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start_i && !abort_i) begin
              step_q        <= (step_i == '0) ? CS_WIDTH'(1) : step_i;
              dwell_q       <= (dwell_count_i == '0) ? DWELL_WIDTH'(1) : dwell_count_i;
              thr_q         <= threshold_i;
              best_mag_q    <= '0;
              best_shift_q  <= '0;
              found_q       <= 1'b0;
              cur_shift_q   <= '0;
              seek_target_q <= '0;
              seek_en_q     <= 1'b1;
              busy_q        <= 1'b1;
              state_q       <= S_SEEK;
            end
          end
          S_SEEK: begin
            if (!seeking_i) begin
              seek_en_q <= 1'b0;
              state_q   <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            acc_clear_q <= 1'b1;
            state_q     <= S_CLEAR;
          end
          S_CLEAR: begin
            dump_cnt_q <= '0;
            bin_sum_q  <= '0;
            state_q    <= S_DWELL;
          end
          S_DWELL: begin
            if (acc_valid_i) begin
              bin_sum_q  <= bin_sum_q + SUM_WIDTH'(acc_mag_i);
              dump_cnt_q <= dump_cnt_q + DWELL_WIDTH'(1);
              if (dump_cnt_q + DWELL_WIDTH'(1) == dwell_q) begin
                state_q <= S_EVAL;
              end
            end
          end
          S_EVAL: begin
            best_mag_q <= best_mag_d;
            if (bin_wins) begin
              best_shift_q <= cur_shift_q;
            end
            if (next_shift > MAX_SHIFT_EXT) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              found_q <= (best_mag_d >= thr_q);
              state_q <= S_DONE;
            end else begin
              cur_shift_q   <= next_shift[CS_WIDTH-1:0];
              seek_target_q <= next_shift[CS_WIDTH-1:0];
              seek_en_q     <= 1'b1;
              state_q       <= S_SEEK;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign seek_en_o     = seek_en_q;
  assign seek_target_o = seek_target_q;
  assign acc_clear_o   = acc_clear_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign found_o       = found_q;
  assign best_shift_o  = best_shift_q;
  assign best_mag_o    = best_mag_q;

endmodule

// File: doc/code_search_ctrl.md
# code_search_ctrl

Serial code-phase search controller for one tracking channel. It steps the C/A upsampler through code-shift bins using the upsampler's seek handshake, clears and collects accumulator dumps for a programmable dwell at each bin, and reports the bin with the largest summed magnitude. It is the initiator side of the seek interface and sits between channel software registers and the upsampler/accumulator pair.

## Interface
- CS_WIDTH, 11: code-shift width; matches upsampler code_shift.
- MAX_CODE_SHIFT, 2045: last legal code shift; the sweep never exceeds it.
- ACC_WIDTH, 24: accumulator magnitude width.
- DWELL_WIDTH, 8: dwell counter width.
- SUM_WIDTH, ACC_WIDTH+DWELL_WIDTH: per-bin sum width; it cannot overflow.
- clk  in  1  system clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-low; 0 resets all state.
- start  in  1  one-cycle pulse that begins a sweep; ignored while busy.
- abort  in  1  terminates the sweep; return to IDLE.
- step  in  CS_WIDTH  shift increment between bins; 0 is treated as 1.
- dwell_count  in  DWELL_WIDTH  number of acc_valid dumps per bin; 0 is treated as 1.
- threshold  in  SUM_WIDTH  detection threshold for the best sum.
- seek_en  out  1  seek request to the upsampler.
- seek_target  out  CS_WIDTH  requested code shift; stable whenever seek_en=1.
- seeking  in  1  upsampler seek-in-progress flag; it is combinational from seek_en/seek_target.
- acc_clear  out  1  one-cycle accumulator clear pulse.
- acc_valid  in  1  accumulator dump strobe.
- acc_mag  in  ACC_WIDTH  magnitude that accompanies acc_valid.
- busy  out  1  high from the cycle after start until done or abort.
- done  out  1  one-cycle pulse when the sweep completes.
- found  out  1  best_mag >= threshold; valid from done until the next start.
- best_shift  out  CS_WIDTH  shift of the best bin.
- best_mag  out  SUM_WIDTH  sum of the best bin.

## Operation
- step, dwell_count and threshold are latched on an accepted start. Changing them mid-sweep has no effect.
- States:
  - IDLE: waits for start.
  - SEEK: seek_en=1.
  - SETTLE: one cycle, seek_en=0.
  - CLEAR: acc_clear=1.
  - DWELL: collects dumps.
  - EVAL: compares the bin.
  - DONE: pulses done, then IDLE.
- start in IDLE does the following:
  - clears best_mag to 0, best_shift to 0 and found to 0;
  - sets cur_shift=0 and seek_target=0;
  - goes to SEEK.
- SEEK: seek_en stays high while seeking=1. On the first cycle with seeking=0, go to SETTLE. This includes the first SEEK cycle when the upsampler is already at or next to the target.
- SETTLE covers the upsampler's one-cycle code_shift lag after seeking drops. Go to CLEAR.
- CLEAR: acc_clear=1 for exactly one cycle. Zero dump_cnt and bin_sum. Go to DWELL.
- DWELL: on each acc_valid, bin_sum += acc_mag and dump_cnt++. The dump that brings dump_cnt to the latched dwell goes to EVAL. acc_valid in any other state is ignored.
- EVAL: if bin_sum > best_mag (strict), update best_mag=bin_sum and best_shift=cur_shift. Then compute next = cur_shift + step at CS_WIDTH+1 bits:
  - if next > MAX_CODE_SHIFT, go to DONE;
  - otherwise cur_shift = seek_target = next and go to SEEK.
- DONE: done=1 for one cycle. found=(best_mag >= threshold), registered in the same cycle. busy drops. Go to IDLE.
- The sweep never wraps. Bin count is floor(MAX_CODE_SHIFT/step)+1.
- abort (any state other than IDLE) acts on the next edge:
  - go to IDLE with seek_en=0 and busy=0;
  - no done pulse, found=0;
  - best_* hold their partial values.
- abort together with start in IDLE: abort wins and start is dropped.

## Timing
- Reset values: seek_en 0, seek_target 0, acc_clear 0, busy 0, done 0, found 0, best_shift 0, best_mag 0. State is IDLE.
- All outputs are registered. No combinational path from seeking/acc_valid to any output.
- start to seek_en=1: 1 cycle. busy rises on the same edge.
- Minimum bin length is 5 cycles: SEEK(1) + SETTLE + CLEAR + DWELL(≥1) + EVAL.
- Last DWELL dump to done: 2 cycles (EVAL, DONE).
- seek_target only changes in EVAL, while seek_en=0.
- On ties, the earliest shift is kept.

## Test plan
- No target: MAX=15, step=4, dwell=2, seeking=0 always, acc_mag=10 per dump. Expect:
  - bins 0, 4, 8, 12 (4 seek pulses);
  - done;
  - best_shift=0, best_mag=20, with threshold 21 giving found=0.
- Peak: same setup, acc_mag=500 at shift 8 only, threshold=900. Expect best_shift=8, best_mag=1000, found=1.
- Seek wait: the model holds seeking=1 for 7 cycles per bin. Expect:
  - seek_en high exactly until the first seeking=0 cycle;
  - acc_clear exactly 2 cycles later;
  - seek_target stable throughout.
- Degenerate: step=0, dwell=0, MAX=3. Expect 4 bins (0..3), 1 dump each. Ties keep best_shift=0.
- Abort and reset: abort during DWELL of bin 2 gives:
  - IDLE next cycle, busy=0;
  - no done, seek_en=0;
  - a new start sweeps again from 0.

  Asserting reset=0 during SEEK immediately returns all outputs to their reset values.
- Stray strobes: acc_valid pulses during SEEK/SETTLE/CLEAR are ignored, so bin_sum counts only DWELL dumps.
